om_otf_convert: RTL
===================

OM_OTF_CONVERT -- requirements
Module: om_otf_convert

Interface
REQ-001 Parameter NDIG, default 8, SHALL set the number of signed digits per operand (MSD first, radix 2).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 nReset  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 start  input  1  SHALL request a new conversion.
REQ-005 d_valid  input  1  SHALL qualify d_dig.
REQ-006 d_dig  input  2  SHALL carry one borrow-save digit {p,n}, value p-n: 10=+1, 01=-1, 00/11=0.
REQ-007 d_ready  output  1  SHALL indicate that a digit is accepted this cycle if d_valid=1.
REQ-008 z  output  NDIG+1  SHALL hold the two's-complement result, 1 sign bit and NDIG fraction bits (value = z*2^-NDIG).
REQ-009 z_valid  output  1  SHALL indicate z holds a completed result.
REQ-010 out_ready  input  1  SHALL indicate the consumer takes z this cycle.
REQ-011 busy  output  1  SHALL be 1 while digits are being collected.

Function
REQ-012 FSM SHALL have states IDLE, COLLECT, DONE, plus registers Q, QM (NDIG+1 bits each) and digit counter cnt (0..NDIG-1).
REQ-013 IDLE: d_ready=0, z_valid=0, busy=0; start=1 -> Q=0, QM=all ones (-1), cnt=0, next COLLECT.
REQ-014 COLLECT: d_ready=1, busy=1; digit accepted iff d_valid=1 and d_ready=1; no transfer leaves all state unchanged.
REQ-015 On accept, d=+1: Q<=(Q<<1)|1, QM<=(Q<<1)|0.
REQ-016 On accept, d=0: Q<=(Q<<1)|0, QM<=(QM<<1)|1.
REQ-017 On accept, d=-1: Q<=(QM<<1)|1, QM<=(QM<<1)|0.
REQ-018 Invariant after j accepted digits: QM = Q-1; Q = sum(d_i*2^(j-i)), no overflow for any digit sequence.
REQ-019 Accept with cnt=NDIG-1 SHALL move to DONE next cycle; otherwise cnt increments.
REQ-020 DONE: z=Q, z_valid=1, d_ready=0, busy=0; z and z_valid SHALL hold stable until out_ready=1.
REQ-021 DONE with out_ready=1 -> IDLE next cycle; start in the same cycle is ignored.
REQ-022 Latency: z_valid SHALL assert exactly one cycle after the NDIG-th digit is accepted.
REQ-023 z SHALL read 0 whenever z_valid=0.
REQ-024 start in DONE SHALL be ignored; start in COLLECT governed by REQ-028/029.

Reset
REQ-025 nReset=0 SHALL immediately force IDLE, Q=0, QM=all ones, cnt=0, z=0, z_valid=0, d_ready=0, busy=0.
REQ-026 Reset asserted mid-COLLECT or in DONE SHALL discard the partial/unconsumed result; no z_valid follows.
REQ-027 After nReset deasserts, the block SHALL wait in IDLE for start.

Configuration
REQ-028 With OM_OTF_ABORT_EN defined, start=1 in COLLECT SHALL restart: Q=0, QM=all ones, cnt=0, stay COLLECT; a digit offered that cycle is not accepted (d_ready=0 that cycle).
REQ-029 Without OM_OTF_ABORT_EN, start=1 in COLLECT SHALL be ignored and d_ready stays 1.

Verification (NDIG=8)
REQ-030 Digits +1,0,0,0,0,0,0,0 with out_ready=1 -> z=9'h080, z_valid one cycle after 8th accept.
REQ-031 Digits -1,+1,0,0,0,0,0,0 -> z=9'h1C0 (-0.25); digits -1 then seven +1 -> z=9'h1FF (-2^-8).
REQ-032 Eight +1 -> z=9'h0FF; eight -1 -> z=9'h101; eight 11 -> z=9'h000.
REQ-033 d_valid toggled 1/0 each cycle during COLLECT, out_ready=0 for 5 cycles in DONE -> same z as REQ-030, z stable all 5 cycles, d_ready=0 in DONE.
REQ-034 nReset pulsed low after 4 digits -> all outputs 0 immediately, no z_valid; fresh start+8 digits converts correctly.
REQ-035 start after 3 digits: with OM_OTF_ABORT_EN -> result from the following 8 digits only; without -> result from original 8 digits.

Source files
------------

// File: rtl/om_otf_convert.sv
// On-the-fly conversion of an MSD-first borrow-save digit stream into a two's-complement fraction.
// Build option: define OM_OTF_ABORT_EN so that start during collection restarts the conversion.
module om_otf_convert #(
  parameter int NDIG = 8
) (
  input  logic          clk,
  input  logic          nReset,
  input  logic          start,
  input  logic          d_valid,
  input  logic [1:0]    d_dig,
  output logic          d_ready,
  output logic [NDIG:0] z,
  output logic          z_valid,
  input  logic          out_ready,
  output logic          busy
);
  localparam int            CW       = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NDIG - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t        state_q;
  logic [NDIG:0] q_q, qm_q;
  logic [NDIG:0] q_d, qm_d;
  logic [CW-1:0] cnt_q;
  logic [NDIG:0] z_q;
  logic          z_valid_q, busy_q, rdy_q;
  logic          abort, accept;

`ifdef OM_OTF_ABORT_EN
  assign abort = (state_q == COLLECT) && start;
`else
  assign abort = 1'b0;
`endif

  assign d_ready = rdy_q && !abort;
  assign accept  = d_ready && d_valid;
  assign z       = z_q;
  assign z_valid = z_valid_q;
  assign busy    = busy_q;

  // Q holds the converted prefix, QM = Q-1, so every digit value is a pure shift-in.
  always_comb begin
    q_d  = {q_q[NDIG-1:0], 1'b0};
    qm_d = {qm_q[NDIG-1:0], 1'b1};
    case (d_dig)
      2'b10: begin
        q_d  = {q_q[NDIG-1:0], 1'b1};
        qm_d = {q_q[NDIG-1:0], 1'b0};
      end
      2'b01: begin
        q_d  = {qm_q[NDIG-1:0], 1'b1};
        qm_d = {qm_q[NDIG-1:0], 1'b0};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q   <= IDLE;
      q_q       <= '0;
      qm_q      <= '1;
      cnt_q     <= '0;
      z_q       <= '0;
      z_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= COLLECT;
            q_q     <= '0;
            qm_q    <= '1;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            rdy_q   <= 1'b1;
          end
        end
        COLLECT: begin
          if (abort) begin
            q_q   <= '0;
            qm_q  <= '1;
            cnt_q <= '0;
          end else if (accept) begin
            q_q  <= q_d;
            qm_q <= qm_d;
            if (cnt_q == CNT_LAST) begin
              state_q   <= DONE;
              busy_q    <= 1'b0;
              rdy_q     <= 1'b0;
              z_valid_q <= 1'b1;
              z_q       <= q_d;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q   <= IDLE;
            z_valid_q <= 1'b0;
            z_q       <= '0;
          end
        end
        default: begin
          state_q   <= IDLE;
          z_valid_q <= 1'b0;
          z_q       <= '0;
          busy_q    <= 1'b0;
          rdy_q     <= 1'b0;
        end
      endcase
    end
  end

endmodule
